// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that feeds one UART transmitter.
// Each packet starts with a channel-ID header byte, and every character is given a fixed frame time.
module uart_tx_arbiter #(
  parameter int                CLOCK        = 50000000,
  parameter int                BAUD         = 9600,
  parameter int                DATA         = 8,
  parameter int                NREQ         = 4,
  parameter int                FRAME_CYCLES = (CLOCK / BAUD) * (DATA + 3),
  parameter int                TIMEOUT      = 65535,
  parameter logic [DATA-1:0]   HDR_BASE     = 8'hF0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA-1:0]     data_in,
  input  logic [NREQ-1:0]          last,
  output logic [NREQ-1:0]          ack,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic [DATA-1:0]          uart_data,
  output logic                     uart_new_data
);

  localparam int IDW = $clog2(NREQ);
  localparam int FCW = $clog2(FRAME_CYCLES + 1);
  localparam int TOW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_ARB  = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_NEXT = 3'd3;
  localparam logic [2:0] S_BYTE = 3'd4;

  logic [2:0]      r_state;
  logic [IDW-1:0]  r_owner;
  logic [IDW-1:0]  r_ptr;
  logic [DATA-1:0] r_uart_data;
  logic [FCW-1:0]  r_frame;
  logic [TOW-1:0]  r_idle;
  logic            r_last_sent;

  logic            w_found_hi, w_found_lo, w_found;
  logic [IDW-1:0]  w_hi, w_lo, w_winner;
  logic            w_own_req, w_own_last;
  logic [DATA-1:0] w_own_data;

  // Rotating priority: lowest requester above the pointer wins, otherwise wrap to the lowest overall.
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        if (IDW'(k) > r_ptr) begin
          w_found_hi = 1'b1;
          w_hi       = IDW'(k);
        end else begin
          w_found_lo = 1'b1;
          w_lo       = IDW'(k);
        end
      end
    end
    w_found  = w_found_hi | w_found_lo;
    w_winner = w_found_hi ? w_hi : w_lo;
  end

  always_comb begin
    w_own_req  = 1'b0;
    w_own_last = 1'b0;
    w_own_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (r_owner == IDW'(k)) begin
        w_own_req  = req[k];
        w_own_last = last[k];
        w_own_data = data_in[k*DATA +: DATA];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_ARB;
      r_owner     <= '0;
      r_ptr       <= IDW'(NREQ - 1);
      r_uart_data <= '0;
      r_frame     <= '0;
      r_idle      <= '0;
      r_last_sent <= 1'b0;
    end else begin
      case (r_state)
        S_ARB: begin
          if (w_found) begin
            r_owner     <= w_winner;
            r_ptr       <= w_winner;
            r_uart_data <= HDR_BASE + DATA'(w_winner);
            r_state     <= S_HDR;
          end
        end
        S_HDR: begin
          r_frame     <= '0;
          r_idle      <= '0;
          r_last_sent <= 1'b0;
          r_state     <= S_WAIT;
        end
        S_BYTE: begin
          r_frame <= '0;
          r_state <= S_WAIT;
        end
        // The UART latches data a cycle after new_data, so uart_data must not move here.
        S_WAIT: begin
          r_frame <= r_frame + 1'b1;
          if (r_frame == FCW'(FRAME_CYCLES - 1)) begin
            r_state <= r_last_sent ? S_ARB : S_NEXT;
          end
        end
        S_NEXT: begin
          if (w_own_req) begin
            r_uart_data <= w_own_data;
            r_last_sent <= w_own_last;
            r_idle      <= '0;
            r_state     <= S_BYTE;
          end else if (r_idle == TOW'(TIMEOUT - 1)) begin
            r_state <= S_ARB;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
        end
        default: r_state <= S_ARB;
      endcase
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ack
    assign ack[gi] = (r_state == S_BYTE) && (r_owner == IDW'(gi));
  end

  assign busy          = (r_state != S_ARB);
  assign uart_new_data = (r_state == S_HDR) || (r_state == S_BYTE);
  assign grant_id      = r_owner;
  assign uart_data     = r_uart_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a timeline model predicts each pulse from the latency rules.
// Directed phases pin that model to hand-computed sequences.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int F    = 20;
  localparam int TO   = 8;
  localparam logic [7:0] HDR = 8'hF0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0, last = '0, ack;
  logic [31:0] data_in = '0;
  logic [1:0]  grant_id;
  logic        busy, uart_new_data;
  logic [7:0]  uart_data;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.CLOCK(50000000), .BAUD(9600), .DATA(8), .NREQ(NREQ),
                    .FRAME_CYCLES(F), .TIMEOUT(TO), .HDR_BASE(HDR)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .last(last), .ack(ack),
    .grant_id(grant_id), .busy(busy), .uart_data(uart_data), .uart_new_data(uart_new_data));

  int total = 0, bad = 0, cyc = 0;

  // requester byte queues: {last, byte}
  logic [8:0] qm [NREQ][256];
  int qh [NREQ], qt [NREQ], off_cnt [NREQ];
  bit en [NREQ];

  // timeline model
  bit in_reset, rel_now, m_locked;
  int m_owner, m_ptr, m_wake, m_giveup, m_arb_at;
  logic       e_nd, e_busy;
  logic [3:0] e_ack;
  logic [1:0] e_grant;
  logic [7:0] e_data;

  // log of observed pulses
  int np = 0;
  int pl_t [1024];
  logic [7:0] pl_v [1024];
  logic [3:0] pl_a [1024];
  logic [1:0] pl_g [1024];
  int t_busy_fall = 0;
  logic prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b, input bit l);
    qm[i][qt[i] % 256] = {l, b};
    qt[i]++;
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = NREQ - 1;
    m_wake = 0; m_giveup = 0; m_arb_at = 0;
    e_nd = 0; e_ack = 0; e_busy = 0; e_grant = 0; e_data = 0;
  endtask

  // Predict outputs of cycle c+1 from the inputs sampled at the end of cycle c.
  task automatic model_step(input int c, input logic [3:0] r, input logic [31:0] d, input logic [3:0] l);
    int n, w, idx;
    n = c + 1;
    e_nd = 0;
    e_ack = 0;
    if (in_reset) begin
      e_data = 0; e_grant = 0; e_busy = 0;
      return;
    end
    if (!m_locked) begin
      if (c >= m_arb_at && r != 0) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (w < 0 && r[idx]) w = idx;
        end
        m_locked = 1; m_owner = w; m_ptr = w;
        e_data = HDR + 8'(w); e_nd = 1;
        m_wake = n + F + 1; m_giveup = m_wake + TO - 1;
      end
    end else if (c >= m_wake) begin
      if (r[m_owner]) begin
        e_nd = 1;
        e_ack = 4'(1 << m_owner);
        e_data = d[m_owner*8 +: 8];
        if (l[m_owner]) begin
          m_locked = 0; m_arb_at = n + F + 1;
        end else begin
          m_wake = n + F + 1; m_giveup = m_wake + TO - 1;
        end
      end else if (c == m_giveup) begin
        m_locked = 0; m_arb_at = n;
      end
    end
    e_grant = 2'(m_owner);
    e_busy = m_locked || (n < m_arb_at);
  endtask

  task automatic cycle();
    logic [8:0] h;
    @(negedge clk);
    chk("cycle_outputs", {16'h0, uart_new_data, ack, busy, grant_id, uart_data},
        {16'h0, e_nd, e_ack, e_busy, e_grant, e_data});
    if (uart_new_data === 1'b1 && np < 1024) begin
      pl_t[np] = cyc; pl_v[np] = uart_data; pl_a[np] = ack; pl_g[np] = grant_id;
      np++;
    end
    if (prev_busy === 1'b1 && busy === 1'b0) t_busy_fall = cyc;
    prev_busy = busy;
    for (int i = 0; i < NREQ; i++) if (e_ack[i] && qt[i] > qh[i]) qh[i]++;
    for (int i = 0; i < NREQ; i++) begin
      if (en[i] && qt[i] > qh[i]) begin
        h = qm[i][qh[i] % 256];
        req[i] = 1'b1; data_in[i*8 +: 8] = h[7:0]; last[i] = h[8];
      end else begin
        req[i] = 1'b0; data_in[i*8 +: 8] = 8'($urandom); last[i] = 1'($urandom);
      end
    end
    if (rel_now) begin
      rst = 1'b1; in_reset = 0; rel_now = 0;
    end
    model_step(cyc, req, data_in, last);
    cyc++;
  endtask

  task automatic random_stim();
    int n;
    for (int i = 0; i < NREQ; i++) begin
      if (qt[i] == qh[i] && $urandom_range(0, 7) == 0) begin
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) push(i, 8'($urandom), k == n - 1);
      end
      if (off_cnt[i] > 0) begin
        off_cnt[i]--; en[i] = 0;
      end else begin
        en[i] = 1;
        if ($urandom_range(0, 59) == 0) off_cnt[i] = $urandom_range(1, 14);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int np0, tcall, trel;
    logic [7:0] exp_rr [8];
    logic [7:0] exp_lk [6];
    logic [7:0] exp_to [6];
    for (int i = 0; i < NREQ; i++) begin
      qh[i] = 0; qt[i] = 0; off_cnt[i] = 0; en[i] = 0;
    end
    in_reset = 1; rel_now = 0;
    model_reset();
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_new_data", uart_new_data, 0);
    chk("reset_ack", ack, 0);
    chk("reset_uart_data", uart_data, 0);
    chk("reset_grant", grant_id, 0);
    repeat (3) cycle();
    rel_now = 1;
    cycle();
    repeat (4) cycle();

    // round-robin among 0, 1, 3 with single-byte packets
    np0 = np;
    push(0, 8'hA0, 1); push(0, 8'hA1, 1); push(1, 8'hB0, 1); push(3, 8'hC0, 1);
    en[0] = 1; en[1] = 1; en[3] = 1;
    repeat (200) cycle();
    exp_rr = '{8'hF0, 8'hA0, 8'hF1, 8'hB0, 8'hF3, 8'hC0, 8'hF0, 8'hA1};
    chk("rr_count", np - np0, 8);
    for (int k = 0; k < 8; k++) chk("rr_seq", pl_v[np0 + k], exp_rr[k]);
    chk("rr_grant0", pl_g[np0], 0);
    chk("rr_grant1", pl_g[np0 + 2], 1);
    chk("rr_grant2", pl_g[np0 + 4], 3);
    chk("rr_grant3", pl_g[np0 + 6], 0);
    en[0] = 0; en[1] = 0; en[3] = 0;

    // single two-byte packet on requester 2
    np0 = np; tcall = cyc;
    push(2, 8'h11, 0); push(2, 8'h22, 1); en[2] = 1;
    repeat (80) cycle();
    chk("single_count", np - np0, 3);
    chk("single_hdr_latency", pl_t[np0] - tcall, 1);
    chk("single_v0", pl_v[np0], 8'hF2);
    chk("single_v1", pl_v[np0 + 1], 8'h11);
    chk("single_v2", pl_v[np0 + 2], 8'h22);
    chk("single_gap1", pl_t[np0 + 1] - pl_t[np0], 22);
    chk("single_gap2", pl_t[np0 + 2] - pl_t[np0 + 1], 22);
    chk("single_ack0", pl_a[np0], 4'b0000);
    chk("single_ack1", pl_a[np0 + 1], 4'b0100);
    chk("single_ack2", pl_a[np0 + 2], 4'b0100);
    chk("single_busy_fall", t_busy_fall - pl_t[np0 + 2], 21);
    en[2] = 0;

    // lock: requester 1 arrives while requester 0 is mid-packet
    np0 = np;
    push(0, 8'h31, 0); push(0, 8'h32, 0); push(0, 8'h33, 1); en[0] = 1;
    for (int k = 0; k < 100 && np - np0 < 2; k++) cycle();
    chk("lock_first_byte_seen", np - np0 >= 2, 1);
    push(1, 8'h41, 1); en[1] = 1;
    repeat (130) cycle();
    exp_lk = '{8'hF0, 8'h31, 8'h32, 8'h33, 8'hF1, 8'h41};
    chk("lock_count", np - np0, 6);
    for (int k = 0; k < 6; k++) chk("lock_seq", pl_v[np0 + k], exp_lk[k]);
    chk("lock_ack3", pl_a[np0 + 3], 4'b0001);
    chk("lock_ack5", pl_a[np0 + 5], 4'b0010);

    // timeout: requester 0 goes quiet after its first byte, requester 1 waits
    np0 = np;
    push(0, 8'h51, 0); push(0, 8'h52, 1); push(1, 8'h61, 1);
    en[0] = 1; en[1] = 1;
    for (int k = 0; k < 100 && np - np0 < 2; k++) cycle();
    chk("timeout_first_byte_seen", np - np0 >= 2, 1);
    en[0] = 0;
    repeat (40) cycle();
    en[0] = 1;
    repeat (150) cycle();
    exp_to = '{8'hF0, 8'h51, 8'hF1, 8'h61, 8'hF0, 8'h52};
    chk("timeout_count", np - np0, 6);
    for (int k = 0; k < 6; k++) chk("timeout_seq", pl_v[np0 + k], exp_to[k]);
    chk("timeout_gap", pl_t[np0 + 2] - pl_t[np0 + 1], 30);

    // reset while a header frame is in flight
    np0 = np;
    en[1] = 0;
    push(2, 8'h71, 0); push(2, 8'h72, 1); en[2] = 1;
    for (int k = 0; k < 50 && np - np0 < 1; k++) cycle();
    repeat (5) cycle();
    chk("rstmid_was_busy", busy, 1);
    rst = 1'b0; in_reset = 1;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_new_data", uart_new_data, 0);
    chk("rstmid_ack", ack, 0);
    chk("rstmid_uart_data", uart_data, 0);
    model_reset();
    for (int i = 0; i < NREQ; i++) qh[i] = qt[i];
    push(0, 8'h81, 1); push(2, 8'h91, 1); en[0] = 1; en[2] = 1;
    repeat (3) cycle();
    np0 = np; trel = cyc;
    rel_now = 1;
    cycle();
    repeat (100) cycle();
    chk("rstmid_first_hdr", pl_v[np0], 8'hF0);
    chk("rstmid_first_time", pl_t[np0] - trel, 1);
    chk("rstmid_byte0", pl_v[np0 + 1], 8'h81);
    chk("rstmid_hdr2", pl_v[np0 + 2], 8'hF2);
    chk("rstmid_byte2", pl_v[np0 + 3], 8'h91);

    // randomized traffic with random req gaps, then drain
    repeat (2500) begin
      random_stim();
      cycle();
    end
    for (int i = 0; i < NREQ; i++) begin
      en[i] = 1; off_cnt[i] = 0;
    end
    repeat (600) cycle();
    chk("end_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit channel between NREQ byte-stream requesters, such as sensor channels in the data logger.
- Arbitrates round-robin at packet granularity and prefixes each packet with a channel-ID header byte.
- Paces bytes into the UART's new_data/data_in interface. The UART exposes no busy flag, so this block times each frame itself.
- Sits between the sensor capture logic and the uart instance.

Parameters:
- CLOCK, 50000000, system clock frequency in Hz.
- BAUD, 9600, UART baud rate.
- DATA, 8, bits per UART character.
- NREQ, 4, number of requesters (2..16).
- FRAME_CYCLES, (CLOCK/BAUD)*(DATA+3), cycles reserved per character: start, DATA bits, stop, plus one guard bit.
- TIMEOUT, 65535, idle cycles allowed mid-packet before the lock is dropped.
- HDR_BASE, 8'hF0, header byte value is HDR_BASE + requester ID.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  req[i] high means requester i presents a valid byte.
- data_in  in  NREQ*DATA  requester i byte is at [i*DATA +: DATA].
- last  in  NREQ  last[i] high means the presented byte ends requester i's packet.
- ack  out  NREQ  one-cycle pulse: the presented byte has been consumed.
- grant_id  out  $clog2(NREQ)  current or last packet owner.
- busy  out  1  high whenever the state is not ARB.
- uart_data  out  DATA  drives the uart data_in.
- uart_new_data  out  1  one-cycle pulse; drives the uart new_data.

Behaviour:
- Reset (rst low, asynchronous) forces:
  - state = ARB, ack = 0, uart_new_data = 0, uart_data = 0, grant_id = 0, busy = 0.
  - RR pointer = NREQ-1, so requester 0 has first priority.
  - Frame and idle counters = 0.
  - A frame in flight is abandoned; the UART shares this reset net.
- States: ARB, HDR, WAIT, NEXT, BYTE.
- ARB:
  - If any req is high, select the first high req searching from pointer+1 modulo NREQ.
  - On the same edge: owner/grant_id <= winner, pointer <= winner, uart_data <= HDR_BASE + winner. Next state HDR.
  - If no req is high, stay in ARB.
- HDR:
  - uart_new_data = 1 for this cycle only.
  - Clear the frame counter and the last_sent flag. Next state WAIT.
- BYTE:
  - uart_new_data = 1 and ack[owner] = 1, this cycle only.
  - Clear the frame counter. Next state WAIT.
- WAIT:
  - Frame counter increments each cycle.
  - At count FRAME_CYCLES-1: go to ARB if last_sent is set, otherwise to NEXT.
  - uart_data is held stable throughout HDR and WAIT, because the UART latches data one cycle after new_data.
- NEXT:
  - If req[owner] is high, capture data_in[owner] into uart_data and last[owner] into last_sent, clear the idle counter, and go to BYTE.
  - Otherwise the idle counter increments. At TIMEOUT-1, go to ARB with no further output; the packet is truncated and the pointer has already advanced.
- Requesters other than the owner are ignored while locked, and their ack stays 0.
- A requester must hold data_in and last stable from req high until its ack.
- Latency:
  - req rising in an idle ARB at cycle t gives the header pulse at t+1.
  - The first payload pulse comes at t+FRAME_CYCLES+3 if req is still high.
  - Byte-to-byte spacing is FRAME_CYCLES+2 cycles.
- Fairness: a requester that holds req continuously gets its next packet only after every other pending requester has sent one packet.
- A single-byte packet is legal: last is set on the first payload byte, so the packet is the header plus one byte.
- Counter widths: $clog2(FRAME_CYCLES+1) and $clog2(TIMEOUT+1); neither counter may wrap.
- At most one ack bit and at most one uart_new_data pulse per FRAME_CYCLES+1 cycles.

Test Plan:
- Bench parameters: FRAME_CYCLES=20, TIMEOUT=8, NREQ=4.
- Single packet:
  - Stimulus: req[2]=1 with bytes 8'h11, 8'h22 (last=1 on 8'h22).
  - Required response: uart_new_data pulses carry F2, 11, 22, spaced 22 cycles apart. ack[2] pulses with the 11 and 22 pulses. busy falls 21 cycles after the last pulse.
- Round-robin:
  - Stimulus: req[0], req[1] and req[3] all held high, each with single-byte packets.
  - Required response: header order F0, F1, F3, F0; grant_id follows 0, 1, 3, 0.
- Lock:
  - Stimulus: req[1] raised while requester 0 is mid-packet.
  - Required response: no F1 header and no ack[1] until requester 0's last byte has been framed.
- Timeout:
  - Stimulus: requester 0 drops req after its first byte, for 8 or more cycles.
  - Required response: return to ARB after 8 idle NEXT cycles with no extra pulse. A pending req[1] then gets header F1.
- Reset mid-frame:
  - Stimulus: rst low during WAIT.
  - Required response: immediately busy=0, uart_new_data=0, ack=0, uart_data=0. After release, requester 0 wins first.
- Hold check:
  - Required response: uart_data is unchanged from each pulse through the end of its WAIT. Each data_in change after ack is not transmitted until the next BYTE pulse.
